// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO result stage behind the signed 32x32 multiplier.
// A MULT issue captures the 64-bit product into a staging register and holds
// it for MPY_LAT cycles before committing it to the architectural HI/LO.
// MFHI/MFLO/MTHI/MTLO are serviced here, and requests arriving while a
// multiply is outstanding are stalled.
//
// Build option: define HILO_FWD_EN to forward the staged product to MFHI/MFLO
// during the commit cycle instead of stalling them for that cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no multiply outstanding; MT writes and MF reads execute
// BUSY  | product staged; cnt counts down; commit to HI/LO when cnt==0

module hilo_unit #(
   parameter int unsigned MPY_LAT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] Y_hi,
   input  logic [31:0] Y_lo,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wr_data,
   input  logic        mfhi,
   input  logic        mflo,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        stall
);

   // A 3-bit down-counter covers latencies 1..8 (load value MPY_LAT-1).
   if (MPY_LAT < 1 || MPY_LAT > 8) begin : g_lat_check
      $error("hilo_unit: MPY_LAT must be in 1..8");
   end

   localparam logic [2:0] CNT_INIT = 3'(MPY_LAT - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q,   cnt_d;
   logic [63:0] staging_q, staging_d;
   logic [31:0] hi_q,    hi_d;
   logic [31:0] lo_q,    lo_d;

   logic        commit;
   logic        rd_req;
   logic        rd_stall;
   logic        wr_stall;

   assign commit = (state_q == BUSY) && (cnt_q == 3'd0);
   assign rd_req = mfhi | mflo;

   // State, counter, staging and architectural registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= 3'd0;
         staging_q <= 64'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         staging_q <= staging_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Next-state: accept MULT or MT writes in IDLE, count down and commit in BUSY.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      staging_d = staging_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               // start wins over a same-cycle MTHI/MTLO, which is dropped
               staging_d = {Y_hi, Y_lo};
               cnt_d     = CNT_INIT;
               state_d   = BUSY;
            end else begin
               if (mthi) hi_d = wr_data;
               if (mtlo) lo_d = wr_data;
            end
         end
         BUSY: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               hi_d    = staging_q[63:32];
               lo_d    = staging_q[31:0];
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q == BUSY);

   // Stall generation; reads may bypass the commit cycle when forwarding is built in.
   always_comb begin
      wr_stall = busy & (start | mthi | mtlo);
`ifdef HILO_FWD_EN
      rd_stall = busy & ~commit & rd_req;
`else
      rd_stall = busy & rd_req;
`endif
      stall = wr_stall | rd_stall;
   end

   // Read mux: mfhi has priority over mflo; nothing is returned while in reset.
   always_comb begin
      rd_data = 32'd0;
      if (reset) begin
`ifdef HILO_FWD_EN
         if (commit) begin
            if (mfhi)      rd_data = staging_q[63:32];
            else if (mflo) rd_data = staging_q[31:0];
         end else begin
            if (mfhi)      rd_data = hi_q;
            else if (mflo) rd_data = lo_q;
         end
`else
         if (mfhi)      rd_data = hi_q;
         else if (mflo) rd_data = lo_q;
`endif
      end
   end

   assign HI = hi_q;
   assign LO = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with MPY_LAT=4.
module tb_hilo_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] Y_hi, Y_lo;
   logic        mthi, mtlo;
   logic [31:0] wr_data;
   logic        mfhi, mflo;
   logic [31:0] HI, LO, rd_data;
   logic        busy, stall;

   int checks = 0;
   int errors = 0;

   hilo_unit #(.MPY_LAT(4)) dut (
      .clk(clk), .reset(reset), .start(start), .Y_hi(Y_hi), .Y_lo(Y_lo),
      .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data), .mfhi(mfhi), .mflo(mflo),
      .HI(HI), .LO(LO), .rd_data(rd_data), .busy(busy), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start = 0; mthi = 0; mtlo = 0; mfhi = 0; mflo = 0;
      Y_hi = 0; Y_lo = 0; wr_data = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with requests active
      clear_inputs();
      reset = 0; start = 1; mthi = 1; mfhi = 1; wr_data = 32'hAAAA5555;
      Y_hi = 32'h1; Y_lo = 32'h2;
      step(); step();
      check("rst_hi", HI, 32'h0);
      check("rst_lo", LO, 32'h0);
      check("rst_busy", {31'd0, busy}, 32'h0);
      check("rst_stall", {31'd0, stall}, 32'h0);
      check("rst_rd", rd_data, 32'h0);
      clear_inputs();
      reset = 1;
      step();
      check("post_rst_busy", {31'd0, busy}, 32'h0);
      check("post_rst_hi", HI, 32'h0);

      // Basic multiply with mflo issued the cycle after start
      start = 1; Y_hi = 32'hFFFFFFFF; Y_lo = 32'hFFFFFFF1;
      step();  // E0
      start = 0; Y_hi = 0; Y_lo = 0; mflo = 1;
      for (int i = 0; i < 4; i++) begin
         check("mul_busy", {31'd0, busy}, 32'h1);
         check("mul_hi_hold", HI, 32'h0);
         check("mul_lo_hold", LO, 32'h0);
         if (i < 3) begin
            check("mul_stall", {31'd0, stall}, 32'h1);
         end else begin
`ifdef HILO_FWD_EN
            check("commit_stall", {31'd0, stall}, 32'h0);
            check("commit_fwd_rd", rd_data, 32'hFFFFFFF1);
`else
            check("commit_stall", {31'd0, stall}, 32'h1);
`endif
         end
         step();
      end
      check("mul_done_busy", {31'd0, busy}, 32'h0);
      check("mul_hi", HI, 32'hFFFFFFFF);
      check("mul_lo", LO, 32'hFFFFFFF1);
      check("mul_rd_stall", {31'd0, stall}, 32'h0);
      check("mul_rd", rd_data, 32'hFFFFFFF1);
      mflo = 0;

      // MT in idle
      mthi = 1; mtlo = 1; wr_data = 32'h12345678;
      check("mt_stall", {31'd0, stall}, 32'h0);
      step();
      mthi = 0; mtlo = 0;
      check("mt_hi", HI, 32'h12345678);
      check("mt_lo", LO, 32'h12345678);
      mtlo = 1; wr_data = 32'hCAFEBABE;
      step();
      mtlo = 0; wr_data = 0;
      check("mtlo_only_lo", LO, 32'hCAFEBABE);
      check("mtlo_only_hi", HI, 32'h12345678);
      mfhi = 1; mflo = 1; #1;
      check("rd_both", rd_data, 32'h12345678);
      mfhi = 0; #1;
      check("rd_lo", rd_data, 32'hCAFEBABE);
      mflo = 0; #1;
      check("rd_none", rd_data, 32'h0);
      mfhi = 1; #1;
      check("rd_hi", rd_data, 32'h12345678);
      mfhi = 0;
      step();

      // Collision: start with mthi, then a second start while busy
      start = 1; mthi = 1; wr_data = 32'hDEADBEEF;
      Y_hi = 32'h11112222; Y_lo = 32'h33334444;
      step();  // E0 accepts first product
      mthi = 0; wr_data = 0;
      Y_hi = 32'h55556666; Y_lo = 32'h77778888;  // start stays held
      check("coll_hi_kept", HI, 32'h12345678);
      for (int i = 0; i < 4; i++) begin
         check("coll_stall", {31'd0, stall}, 32'h1);
         check("coll_hi_hold", HI, 32'h12345678);
         step();
      end
      check("coll_first_hi", HI, 32'h11112222);
      check("coll_first_lo", LO, 32'h33334444);
      check("coll_idle_stall", {31'd0, stall}, 32'h0);
      step();  // second start accepted
      start = 0; Y_hi = 0; Y_lo = 0;
      check("coll_second_busy", {31'd0, busy}, 32'h1);
      step(); step(); step();
      check("coll_second_hold", HI, 32'h11112222);
      step();
      check("coll_second_hi", HI, 32'h55556666);
      check("coll_second_lo", LO, 32'h77778888);
      check("coll_second_idle", {31'd0, busy}, 32'h0);

      // Reset mid-operation at cnt==1
      start = 1; Y_hi = 32'h9999AAAA; Y_lo = 32'hBBBBCCCC;
      step();  // E0, cnt=3
      start = 0; Y_hi = 0; Y_lo = 0;
      step(); step();  // cnt=1
      check("abort_busy_before", {31'd0, busy}, 32'h1);
      reset = 0; #1;
      check("abort_hi", HI, 32'h0);
      check("abort_lo", LO, 32'h0);
      check("abort_busy", {31'd0, busy}, 32'h0);
      step(); step();
      reset = 1;
      for (int i = 0; i < 6; i++) step();
      check("abort_no_commit_hi", HI, 32'h0);
      check("abort_no_commit_lo", LO, 32'h0);
      check("abort_idle", {31'd0, busy}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
